// File: rtl/tlu_emulator.sv
// TLU emulator: stands in for an EUDET TLU on the board's trigger input.
// Simple mode issues fixed-length TLU_TRIGGER pulses. Handshake mode raises
// TLU_TRIGGER, waits for TLU_BUSY, then shifts the trigger number out LSB
// first, one bit per TLU_CLOCK rising edge. Any handshake wait longer than
// TIMEOUT cycles aborts the sequence.
module tlu_emulator #(
   parameter int TRIGGER_BITS = 15,
   parameter int PULSE_LEN    = 4,
   parameter int TIMEOUT      = 65535
) (
   input  logic                    BUS_CLK,
   input  logic                    BUS_RST_B,
   input  logic                    ENABLE,
   input  logic                    HANDSHAKE,
   input  logic                    TRIG_REQ,
   input  logic                    RESET_REQ,
   input  logic                    TLU_BUSY,
   input  logic                    TLU_CLOCK,
   output logic                    TLU_TRIGGER,
   output logic                    TLU_RESET,
   output logic [TRIGGER_BITS-1:0] TRIGGER_NUMBER,
   output logic                    READY,
   output logic                    TIMEOUT_ERR,
   output logic [7:0]              MISSED_CNT
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam int PL_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam int BC_W = (TRIGGER_BITS > 1) ? $clog2(TRIGGER_BITS) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_LEN - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(TRIGGER_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT_BUSY,
      S_WAIT_CLK,
      S_WAIT_UNBUSY,
      S_RST_PULSE
   } state_t;

   state_t state, state_d;

   logic busy_meta, busy_sync;
   logic clk_meta, clk_sync, clk_prev;
   logic clk_edge;

   logic                    trig, trig_d;
   logic                    tlu_rst, tlu_rst_d;
   logic [TRIGGER_BITS-1:0] trig_num, trig_num_d;
   logic [TRIGGER_BITS-1:0] shift, shift_d;
   logic [BC_W-1:0]         bit_cnt, bit_cnt_d;
   logic [PL_W-1:0]         pcnt, pcnt_d;
   logic [TO_W-1:0]         to_cnt, to_cnt_d;
   logic                    err, err_d;
   logic [7:0]              missed, missed_d;
   logic                    accept;

   // Two-stage synchronisers for the DUT-side lines plus an edge-detect stage on TLU_CLOCK.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!BUS_RST_B) begin
         busy_meta <= 1'b0;
         busy_sync <= 1'b0;
         clk_meta  <= 1'b0;
         clk_sync  <= 1'b0;
         clk_prev  <= 1'b0;
      end else begin
         busy_meta <= TLU_BUSY;
         busy_sync <= busy_meta;
         clk_meta  <= TLU_CLOCK;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
      end
   end

   assign clk_edge = clk_sync & ~clk_prev;

   // State register.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
      if (!BUS_RST_B) state <= S_IDLE;
      else            state <= state_d;
   end

   // Next-state and next-datapath logic. On the last bit the line keeps that
   // bit until the following TLU_CLOCK edge (in WAIT_UNBUSY) drives it to 0,
   // so the receiver can sample every bit after its own edge.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_d    = state;
      trig_d     = trig;
      tlu_rst_d  = tlu_rst;
      trig_num_d = trig_num;
      shift_d    = shift;
      bit_cnt_d  = bit_cnt;
      pcnt_d     = pcnt;
      to_cnt_d   = to_cnt + 1'b1;
      err_d      = err;
      accept     = 1'b0;
      unique case (state)
         S_IDLE: begin
            pcnt_d   = '0;
            to_cnt_d = '0;
            if (RESET_REQ) begin
               state_d    = S_RST_PULSE;
               tlu_rst_d  = 1'b1;
               trig_num_d = '0;
               err_d      = 1'b0;
            end else if (TRIG_REQ && ENABLE) begin
               accept  = 1'b1;
               trig_d  = 1'b1;
               state_d = HANDSHAKE ? S_WAIT_BUSY : S_PULSE;
            end
         end
         S_PULSE: begin
            if (pcnt == PL_LAST) begin
               trig_d     = 1'b0;
               trig_num_d = trig_num + 1'b1;
               state_d    = S_IDLE;
            end else begin
               pcnt_d = pcnt + 1'b1;
            end
         end
         S_RST_PULSE: begin
            if (pcnt == PL_LAST) begin
               tlu_rst_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               pcnt_d = pcnt + 1'b1;
            end
         end
         S_WAIT_BUSY: begin
            if (to_cnt == TO_LAST) begin
               err_d      = 1'b1;
               trig_d     = 1'b0;
               trig_num_d = trig_num + 1'b1;
               state_d    = S_IDLE;
            end else if (busy_sync) begin
               shift_d   = trig_num;
               trig_d    = 1'b0;
               bit_cnt_d = '0;
               to_cnt_d  = '0;
               state_d   = S_WAIT_CLK;
            end
         end
         S_WAIT_CLK: begin
            if (!busy_sync) begin
               trig_d   = 1'b0;
               to_cnt_d = '0;
               state_d  = S_WAIT_UNBUSY;
            end else if (clk_edge) begin
               trig_d   = shift[0];
               shift_d  = shift >> 1;
               to_cnt_d = '0;
               if (bit_cnt == BC_LAST) state_d = S_WAIT_UNBUSY;
               else                    bit_cnt_d = bit_cnt + 1'b1;
            end else if (to_cnt == TO_LAST) begin
               err_d      = 1'b1;
               trig_d     = 1'b0;
               trig_num_d = trig_num + 1'b1;
               state_d    = S_IDLE;
            end
         end
         S_WAIT_UNBUSY: begin
            if (!busy_sync) begin
               trig_d     = 1'b0;
               trig_num_d = trig_num + 1'b1;
               state_d    = S_IDLE;
            end else if (clk_edge) begin
               trig_d   = 1'b0;
               to_cnt_d = '0;
            end else if (to_cnt == TO_LAST) begin
               err_d      = 1'b1;
               trig_d     = 1'b0;
               trig_num_d = trig_num + 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      missed_d = missed;
      if (TRIG_REQ && ENABLE && !accept && (missed != 8'hFF)) missed_d = missed + 1'b1;
   end

   // Datapath registers: output lines, trigger number, shifter and counters.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
      if (!BUS_RST_B) begin
         trig     <= 1'b0;
         tlu_rst  <= 1'b0;
         trig_num <= '0;
         shift    <= '0;
         bit_cnt  <= '0;
         pcnt     <= '0;
         to_cnt   <= '0;
         err      <= 1'b0;
         missed   <= '0;
      end else begin
         trig     <= trig_d;
         tlu_rst  <= tlu_rst_d;
         trig_num <= trig_num_d;
         shift    <= shift_d;
         bit_cnt  <= bit_cnt_d;
         pcnt     <= pcnt_d;
         to_cnt   <= to_cnt_d;
         err      <= err_d;
         missed   <= missed_d;
      end
   end

   assign TLU_TRIGGER    = trig;
   assign TLU_RESET      = tlu_rst;
   assign TRIGGER_NUMBER = trig_num;
   assign READY          = (state == S_IDLE);
   assign TIMEOUT_ERR    = err;
   assign MISSED_CNT     = missed;

endmodule

// File: tb/tb_tlu_emulator.sv
// Directed bench for tlu_emulator: simple pulses, serial handshake, wrap,
// timeout, request overload and asynchronous reset mid-handshake.
module tb_tlu_emulator;

   logic        BUS_CLK   = 1'b0;
   logic        BUS_RST_B = 1'b0;
   logic        ENABLE    = 1'b0;
   logic        HANDSHAKE = 1'b0;
   logic        TRIG_REQ  = 1'b0;
   logic        RESET_REQ = 1'b0;
   logic        TLU_BUSY  = 1'b0;
   logic        TLU_CLOCK = 1'b0;
   logic        TLU_TRIGGER;
   logic        TLU_RESET;
   logic [14:0] TRIGGER_NUMBER;
   logic        READY;
   logic        TIMEOUT_ERR;
   logic [7:0]  MISSED_CNT;

   int errors = 0;
   int checks = 0;

   tlu_emulator #(
      .TRIGGER_BITS(15),
      .PULSE_LEN   (4),
      .TIMEOUT     (100)
   ) dut (
      .BUS_CLK       (BUS_CLK),
      .BUS_RST_B     (BUS_RST_B),
      .ENABLE        (ENABLE),
      .HANDSHAKE     (HANDSHAKE),
      .TRIG_REQ      (TRIG_REQ),
      .RESET_REQ     (RESET_REQ),
      .TLU_BUSY      (TLU_BUSY),
      .TLU_CLOCK     (TLU_CLOCK),
      .TLU_TRIGGER   (TLU_TRIGGER),
      .TLU_RESET     (TLU_RESET),
      .TRIGGER_NUMBER(TRIGGER_NUMBER),
      .READY         (READY),
      .TIMEOUT_ERR   (TIMEOUT_ERR),
      .MISSED_CNT    (MISSED_CNT)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   // Hard time limit so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue a one-cycle request; returns at the negedge after the accepting edge.
   task automatic start_trigger(input logic hs);
      TRIG_REQ  = 1'b1;
      HANDSHAKE = hs;
      @(negedge BUS_CLK);
      TRIG_REQ  = 1'b0;
   endtask

   // Receiver model: slow TLU_CLOCK, sample the line just before each falling edge.
   task automatic clock_bits(input int n, output logic [31:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         TLU_CLOCK = 1'b1;
         repeat (8) @(negedge BUS_CLK);
         rx[i] = TLU_TRIGGER;
         TLU_CLOCK = 1'b0;
         repeat (8) @(negedge BUS_CLK);
      end
   endtask

   // Full handshake with 15 clocks; returns the received word.
   task automatic run_handshake(output logic [31:0] rx);
      start_trigger(1'b1);
      repeat (4) @(negedge BUS_CLK);
      TLU_BUSY = 1'b1;
      repeat (5) @(negedge BUS_CLK);
      clock_bits(15, rx);
      TLU_BUSY = 1'b0;
      repeat (5) @(negedge BUS_CLK);
   endtask

   task automatic test_reset();
      BUS_RST_B = 1'b0;
      repeat (3) @(negedge BUS_CLK);
      checks++;
      if ({TLU_TRIGGER, TLU_RESET, READY, TIMEOUT_ERR} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0010", {TLU_TRIGGER, TLU_RESET, READY, TIMEOUT_ERR});
      end
      checks++;
      if (TRIGGER_NUMBER !== 15'h0000) begin
         errors++;
         $display("FAIL reset_number: got %h expected 0000", TRIGGER_NUMBER);
      end
      checks++;
      if (MISSED_CNT !== 8'h00) begin
         errors++;
         $display("FAIL reset_missed: got %h expected 00", MISSED_CNT);
      end
      BUS_RST_B = 1'b1;
      repeat (2) @(negedge BUS_CLK);
   endtask

   task automatic test_simple();
      int high;
      ENABLE = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start_trigger(1'b0);
         checks++;
         if (TLU_TRIGGER !== 1'b1) begin
            errors++;
            $display("FAIL simple_first_cycle[%0d]: got %b expected 1", k, TLU_TRIGGER);
         end
         high = 0;
         for (int c = 0; c < 10; c++) begin
            if (TLU_TRIGGER === 1'b1) high++;
            TLU_BUSY  = ~TLU_BUSY;
            TLU_CLOCK = ~TLU_CLOCK;
            @(negedge BUS_CLK);
         end
         checks++;
         if (high != 4) begin
            errors++;
            $display("FAIL simple_pulse_len[%0d]: got %0d expected 4", k, high);
         end
         checks++;
         if (TRIGGER_NUMBER !== 15'(k + 1)) begin
            errors++;
            $display("FAIL simple_number[%0d]: got %h expected %h", k, TRIGGER_NUMBER, 15'(k + 1));
         end
      end
      checks++;
      if ({READY, TLU_RESET} !== 2'b10) begin
         errors++;
         $display("FAIL simple_ready: got %b expected 10", {READY, TLU_RESET});
      end
      TLU_BUSY  = 1'b0;
      TLU_CLOCK = 1'b0;
      repeat (4) @(negedge BUS_CLK);
   endtask

   task automatic test_handshake();
      logic [31:0] rx;
      force dut.trig_num = 15'h2A5B;
      @(negedge BUS_CLK);
      release dut.trig_num;
      @(negedge BUS_CLK);
      checks++;
      if (TRIGGER_NUMBER !== 15'h2A5B) begin
         errors++;
         $display("FAIL hs_preset: got %h expected 2a5b", TRIGGER_NUMBER);
      end
      start_trigger(1'b1);
      checks++;
      if ({TLU_TRIGGER, READY} !== 2'b10) begin
         errors++;
         $display("FAIL hs_trigger_up: got %b expected 10", {TLU_TRIGGER, READY});
      end
      repeat (4) @(negedge BUS_CLK);
      TLU_BUSY = 1'b1;
      @(negedge BUS_CLK);
      checks++;
      if (TLU_TRIGGER !== 1'b1) begin
         errors++;
         $display("FAIL hs_hold_until_busy: got %b expected 1", TLU_TRIGGER);
      end
      repeat (4) @(negedge BUS_CLK);
      checks++;
      if (TLU_TRIGGER !== 1'b0) begin
         errors++;
         $display("FAIL hs_trigger_drop: got %b expected 0", TLU_TRIGGER);
      end
      clock_bits(15, rx);
      checks++;
      if (rx[14:0] !== 15'h2A5B) begin
         errors++;
         $display("FAIL hs_serial_data: got %h expected 2a5b", rx[14:0]);
      end
      checks++;
      if (READY !== 1'b0) begin
         errors++;
         $display("FAIL hs_busy_hold: got READY=%b expected 0", READY);
      end
      TLU_BUSY = 1'b0;
      repeat (4) @(negedge BUS_CLK);
      checks++;
      if ({READY, TLU_TRIGGER, TIMEOUT_ERR} !== 3'b100) begin
         errors++;
         $display("FAIL hs_done_flags: got %b expected 100", {READY, TLU_TRIGGER, TIMEOUT_ERR});
      end
      checks++;
      if (TRIGGER_NUMBER !== 15'h2A5C) begin
         errors++;
         $display("FAIL hs_number: got %h expected 2a5c", TRIGGER_NUMBER);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rx;
      force dut.trig_num = 15'h7FFF;
      @(negedge BUS_CLK);
      release dut.trig_num;
      @(negedge BUS_CLK);
      run_handshake(rx);
      checks++;
      if (rx[14:0] !== 15'h7FFF) begin
         errors++;
         $display("FAIL wrap_data: got %h expected 7fff", rx[14:0]);
      end
      checks++;
      if (TRIGGER_NUMBER !== 15'h0000) begin
         errors++;
         $display("FAIL wrap_number: got %h expected 0000", TRIGGER_NUMBER);
      end
   endtask

   task automatic test_overload();
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               TRIG_REQ  = 1'b1;
               HANDSHAKE = 1'b1;
               @(negedge BUS_CLK);
            end
            TRIG_REQ = 1'b0;
         end
         begin
            logic [31:0] dummy;
            repeat (2) @(negedge BUS_CLK);
            TLU_BUSY = 1'b1;
            clock_bits(20, dummy);
         end
      join
      checks++;
      if (READY !== 1'b0) begin
         errors++;
         $display("FAIL overload_still_busy: got READY=%b expected 0", READY);
      end
      TLU_BUSY = 1'b0;
      repeat (5) @(negedge BUS_CLK);
      checks++;
      if (MISSED_CNT !== 8'hFF) begin
         errors++;
         $display("FAIL overload_missed: got %h expected ff", MISSED_CNT);
      end
      checks++;
      if (TRIGGER_NUMBER !== 15'h0001) begin
         errors++;
         $display("FAIL overload_one_trigger: got %h expected 0001", TRIGGER_NUMBER);
      end
      checks++;
      if ({READY, TIMEOUT_ERR} !== 2'b10) begin
         errors++;
         $display("FAIL overload_flags: got %b expected 10", {READY, TIMEOUT_ERR});
      end
   endtask

   task automatic test_timeout();
      int high;
      int rst_high;
      start_trigger(1'b1);
      high = 0;
      for (int c = 0; c < 120; c++) begin
         if (TLU_TRIGGER === 1'b1) high++;
         @(negedge BUS_CLK);
      end
      checks++;
      if (high != 100) begin
         errors++;
         $display("FAIL timeout_high_time: got %0d expected 100", high);
      end
      checks++;
      if ({TIMEOUT_ERR, READY, TLU_TRIGGER} !== 3'b110) begin
         errors++;
         $display("FAIL timeout_flags: got %b expected 110", {TIMEOUT_ERR, READY, TLU_TRIGGER});
      end
      checks++;
      if (TRIGGER_NUMBER !== 15'h0002) begin
         errors++;
         $display("FAIL timeout_number: got %h expected 0002", TRIGGER_NUMBER);
      end
      RESET_REQ = 1'b1;
      @(negedge BUS_CLK);
      RESET_REQ = 1'b0;
      rst_high = 0;
      for (int c = 0; c < 10; c++) begin
         if (TLU_RESET === 1'b1) rst_high++;
         @(negedge BUS_CLK);
      end
      checks++;
      if (rst_high != 4) begin
         errors++;
         $display("FAIL reset_pulse_len: got %0d expected 4", rst_high);
      end
      checks++;
      if ({TIMEOUT_ERR, READY} !== 2'b01) begin
         errors++;
         $display("FAIL reset_req_flags: got %b expected 01", {TIMEOUT_ERR, READY});
      end
      checks++;
      if (TRIGGER_NUMBER !== 15'h0000) begin
         errors++;
         $display("FAIL reset_req_number: got %h expected 0000", TRIGGER_NUMBER);
      end
      checks++;
      if (MISSED_CNT !== 8'hFF) begin
         errors++;
         $display("FAIL reset_req_keeps_missed: got %h expected ff", MISSED_CNT);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] rx;
      force dut.trig_num = 15'h5555;
      @(negedge BUS_CLK);
      release dut.trig_num;
      @(negedge BUS_CLK);
      start_trigger(1'b1);
      repeat (4) @(negedge BUS_CLK);
      TLU_BUSY = 1'b1;
      repeat (5) @(negedge BUS_CLK);
      clock_bits(7, rx);
      checks++;
      if (rx[6:0] !== 7'h55) begin
         errors++;
         $display("FAIL areset_partial_data: got %h expected 55", rx[6:0]);
      end
      checks++;
      if ({TLU_TRIGGER, READY} !== 2'b10) begin
         errors++;
         $display("FAIL areset_before: got %b expected 10", {TLU_TRIGGER, READY});
      end
      #2;
      BUS_RST_B = 1'b0;
      #1;
      checks++;
      if ({TLU_TRIGGER, TLU_RESET, READY, TIMEOUT_ERR} !== 4'b0010) begin
         errors++;
         $display("FAIL areset_flags: got %b expected 0010", {TLU_TRIGGER, TLU_RESET, READY, TIMEOUT_ERR});
      end
      checks++;
      if ({TRIGGER_NUMBER, MISSED_CNT} !== 23'h0) begin
         errors++;
         $display("FAIL areset_counts: got number=%h missed=%h expected 0000/00", TRIGGER_NUMBER, MISSED_CNT);
      end
      TLU_BUSY = 1'b0;
      @(negedge BUS_CLK);
      BUS_RST_B = 1'b1;
      repeat (3) @(negedge BUS_CLK);
      start_trigger(1'b0);
      repeat (8) @(negedge BUS_CLK);
      checks++;
      if (TRIGGER_NUMBER !== 15'h0001) begin
         errors++;
         $display("FAIL areset_restart_number: got %h expected 0001", TRIGGER_NUMBER);
      end
      run_handshake(rx);
      checks++;
      if (rx[14:0] !== 15'h0001) begin
         errors++;
         $display("FAIL areset_fresh_data: got %h expected 0001", rx[14:0]);
      end
      checks++;
      if ({TRIGGER_NUMBER, READY} !== {15'h0002, 1'b1}) begin
         errors++;
         $display("FAIL areset_final: got number=%h ready=%b expected 0002/1", TRIGGER_NUMBER, READY);
      end
   endtask

   initial begin
      @(negedge BUS_CLK);
      test_reset();
      test_simple();
      test_handshake();
      test_wrap();
      test_overload();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
